period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Front-end stage of the frequency counter, directly upstream of the frequency calculator.
- Synchronises the raw input signal and measures the number of clk cycles between consecutive rising edges.
- Optionally averages 2^AVG_LOG2 periods, then publishes a 24-bit period with a one-cycle valid strobe.
- Reports 0 with a timeout flag when the input stops toggling, so downstream forces frequency to 0.

Parameters:
- AVG_LOG2, 0, log2 of periods averaged per published result (0..4).
- MIN_PERIOD, 4, qualifying rises closer than this many cycles are ignored as glitches (>=2).
- TIMEOUT_CYCLES, 16777215, cycles without a qualifying rise before timeout (<= 2^24-1).

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- signal_in  input  1  asynchronous signal under measurement.
- period  output  24  published period in clk cycles; 0 = no signal.
- period_valid  output  1  one-cycle pulse when period is updated.
- timeout  output  1  high while the last published result was a timeout.

Behaviour:
- Reset: async on rst_n low. All regs clear: sync s1/s2, delay d, cnt, sum, nsamp, period=0, period_valid=0, timeout=0, state=IDLE.
- Sync: s1<=signal_in, s2<=s1, d<=s2.
- rise = s2 & ~d. It is high 3 clk edges after an input rising edge meets setup.
- qrise = rise && (state==IDLE || cnt >= MIN_PERIOD). A non-qualifying rise is ignored and cnt keeps incrementing.
- IDLE: cnt held at 0. On qrise, go to ARM with cnt<=1.
- ARM (warm-up, discards first period, which covers a spurious rise at reset release):
  - qrise: go to MEASURE, cnt<=1, nothing accumulated.
  - Otherwise cnt<=cnt+1.
- MEASURE:
  - qrise: sum<=sum+cnt, nsamp<=nsamp+1, cnt<=1.
  - Otherwise cnt<=cnt+1.
  - Measured value equals the cycle distance between the two rise cycles.
- Publish: when nsamp reaches 2^AVG_LOG2 (after the accumulating edge):
  - Next cycle: period<=sum>>AVG_LOG2 (truncate), period_valid=1 for exactly one cycle, timeout<=0, sum<=0, nsamp<=0.
  - The next accumulate may occur in the same cycle as publish; sum restarts with that sample.
  - With AVG_LOG2=0, every MEASURE qrise publishes.
- Widths: sum is 24+AVG_LOG2 bits and cannot overflow because cnt <= TIMEOUT_CYCLES.
- Timeout: in ARM or MEASURE, when cnt == TIMEOUT_CYCLES and no qrise this cycle:
  - period<=0, timeout<=1, period_valid pulse.
  - sum, nsamp, cnt cleared; state goes to IDLE.
  - A qrise in the same cycle wins: a normal accumulate of TIMEOUT_CYCLES, no timeout.
- IDLE after timeout: period stays 0 and timeout stays 1 until the next publish.
- Signal held high or low: no rises, so timeout follows; constant level is never reported as a period.
- Reset mid-measurement: everything clears immediately. After release, two qualifying rises are discarded before accumulation starts.
- period_valid never asserts on consecutive cycles except where a timeout immediately follows a publish (not reachable, since MIN_PERIOD>=2).

Test Plan:
- Reset release with signal_in=1, then square wave period 1000 cycles, AVG_LOG2=0 -> spurious/first rises discarded; each subsequent rise gives period=1000 with one-cycle period_valid 4 cycles after the input edge; timeout=0.
- AVG_LOG2=2, periods 1000,1001,1002,1003 -> single valid with period=1001 (4006>>2); no valid on intermediate edges.
- Square wave 1000 cycles with 1-cycle glitch pulses inserted 2 cycles after each edge, MIN_PERIOD=4 -> glitches ignored, period stays 1000.
- TIMEOUT_CYCLES=5000, wave at 1000 then signal stuck low -> valid with period=0, timeout=1 at cnt==5000. Restart wave -> first published 1000 clears timeout.
- TIMEOUT_CYCLES=5000, wave period exactly 5000 -> qrise coincides with cnt==5000; period=5000 published, no timeout.
- rst_n pulsed low mid-period -> outputs 0 asynchronously; after release, two edges discarded before the next valid.

Source files
------------

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Brief    : Synchronises signal_in, measures clk cycles between rising edges,
//            optionally averages 2^AVG_LOG2 periods and flags input timeouts.
// Revision : 1.0
// ============================================================================
module period_meter #(
    parameter int unsigned AVG_LOG2       = 0,
    parameter int unsigned MIN_PERIOD     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signal_in,
    output logic [23:0] period,
    output logic        period_valid,
    output logic        timeout
);

    localparam int unsigned c_SUM_W = 24 + AVG_LOG2;
    localparam int unsigned c_NS_W  = AVG_LOG2 + 1;
    localparam logic [c_NS_W-1:0] c_NSAMP_FULL = c_NS_W'(1 << AVG_LOG2);
    localparam logic [23:0] c_MIN_PERIOD = 24'(MIN_PERIOD);
    localparam logic [23:0] c_TIMEOUT    = 24'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_s1;
    logic                r_s2;
    logic                r_d;
    logic [23:0]         r_cnt;
    logic [23:0]         w_cnt_next;
    logic [c_SUM_W-1:0]  r_sum;
    logic [c_SUM_W-1:0]  w_sum_next;
    logic [c_NS_W-1:0]   r_nsamp;
    logic [c_NS_W-1:0]   w_nsamp_next;
    logic [23:0]         r_period;
    logic [23:0]         w_period_next;
    logic                r_valid;
    logic                w_valid_next;
    logic                r_timeout;
    logic                w_timeout_next;
    logic                w_rise;
    logic                w_qrise;
    logic                w_publish;
    logic                w_timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_d       <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_nsamp   <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_s1      <= signal_in;
            r_s2      <= r_s1;
            r_d       <= r_s2;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_sum     <= w_sum_next;
            r_nsamp   <= w_nsamp_next;
            r_period  <= w_period_next;
            r_valid   <= w_valid_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_rise         = r_s2 & ~r_d;
        w_qrise        = w_rise && ((r_state == S_IDLE) || (r_cnt >= c_MIN_PERIOD));
        w_publish      = (r_nsamp == c_NSAMP_FULL);
        w_timeout_hit  = (r_state != S_IDLE) && (r_cnt == c_TIMEOUT) && !w_qrise;

        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_sum_next     = r_sum;
        w_nsamp_next   = r_nsamp;
        w_period_next  = r_period;
        w_valid_next   = 1'b0;
        w_timeout_next = r_timeout;

        // Publishing empties the accumulator first so a sample landing in the
        // same cycle starts the next average.
        if (w_publish) begin
            w_period_next  = r_sum[AVG_LOG2 +: 24];
            w_valid_next   = 1'b1;
            w_timeout_next = 1'b0;
            w_sum_next     = '0;
            w_nsamp_next   = '0;
        end

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_qrise) begin
                    w_state_next = S_ARM;
                    w_cnt_next   = 24'd1;
                end
            end
            S_ARM: begin
                if (w_qrise) begin
                    w_state_next = S_MEASURE;
                    w_cnt_next   = 24'd1;
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            S_MEASURE: begin
                if (w_qrise) begin
                    w_sum_next   = w_sum_next + c_SUM_W'(r_cnt);
                    w_nsamp_next = w_nsamp_next + c_NS_W'(1);
                    w_cnt_next   = 24'd1;
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // A dead input reports zero and restarts the warm-up sequence.
        if (w_timeout_hit) begin
            w_period_next  = '0;
            w_timeout_next = 1'b1;
            w_valid_next   = 1'b1;
            w_sum_next     = '0;
            w_nsamp_next   = '0;
            w_cnt_next     = '0;
            w_state_next   = S_IDLE;
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_meter
// Brief    : Scoreboard bench driving two period_meter instances (AVG_LOG2 0
//            and 2) from one input waveform.
// Revision : 1.0
// ============================================================================
module tb_period_meter;

    localparam int c_HI = 400;
    localparam int c_TO = 5000;

    typedef struct {
        logic [23:0] period;
        logic        to;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        signal_in;
    logic [23:0] period0;
    logic        valid0;
    logic        timeout0;
    logic [23:0] period1;
    logic        valid1;
    logic        timeout1;

    int   cyc    = 0;
    int   last   = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    period_meter #(.AVG_LOG2(0), .MIN_PERIOD(4), .TIMEOUT_CYCLES(c_TO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
        .period(period0), .period_valid(valid0), .timeout(timeout0)
    );

    period_meter #(.AVG_LOG2(2), .MIN_PERIOD(4), .TIMEOUT_CYCLES(c_TO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
        .period(period1), .period_valid(valid1), .timeout(timeout1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one rising edge gap cycles after the previous one, queueing the
    // results it should produce before the DUTs can report them.
    task automatic rise(input int gap, input bit glitch, input bit p0, input bit p1,
                        input int v0, input int v1);
        int tgt;
        tgt = last + gap;
        while (cyc < tgt) @(negedge clk);
        signal_in = 1'b1;
        last = cyc;
        if (p0) q0.push_back('{24'(v0), 1'b0, last + 4});
        if (p1) q1.push_back('{24'(v1), 1'b0, last + 4});
        if (glitch) begin
            repeat (2) @(negedge clk);
            signal_in = 1'b0;
            @(negedge clk);
            signal_in = 1'b1;
        end
        while (cyc < last + c_HI) @(negedge clk);
        signal_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid0) begin
            chk("dut0_valid_expected", 64'(q0.size() > 0), 64'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("dut0_period", 64'(period0), 64'(e0.period));
                chk("dut0_timeout", 64'(timeout0), 64'(e0.to));
                chk("dut0_valid_cycle", 64'(cyc), 64'(e0.cyc));
            end
        end
        if (rst_n && valid1) begin
            chk("dut1_valid_expected", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("dut1_period", 64'(period1), 64'(e1.period));
                chk("dut1_timeout", 64'(timeout1), 64'(e1.to));
                chk("dut1_valid_cycle", 64'(cyc), 64'(e1.cyc));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        signal_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_period0", 64'(period0), 64'd0);
        chk("reset_valid0", 64'(valid0), 64'd0);
        chk("reset_timeout0", 64'(timeout0), 64'd0);
        chk("reset_period1", 64'(period1), 64'd0);
        chk("reset_valid1", 64'(valid1), 64'd0);
        chk("reset_timeout1", 64'(timeout1), 64'd0);

        // Release with the input high: spurious rise, then R1, both discarded.
        rst_n = 1'b1;
        last  = cyc;
        repeat (20) @(negedge clk);
        signal_in = 1'b0;
        rise(600, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 4; i++) rise(1000, 1'b0, 1'b1, i == 3, 1000, 1000);
        for (int i = 0; i < 4; i++) rise(1000 + i, 1'b0, 1'b1, i == 3, 1000 + i, 1001);
        for (int i = 0; i < 4; i++) rise(1000, 1'b1, 1'b1, i == 3, 1000, 1000);

        // Input stuck low after the last rise.
        q0.push_back('{24'd0, 1'b1, last + 3 + c_TO});
        q1.push_back('{24'd0, 1'b1, last + 3 + c_TO});
        while (cyc < last + c_TO + 10) @(negedge clk);
        chk("idle_timeout0", 64'(timeout0), 64'd1);
        chk("idle_period0", 64'(period0), 64'd0);
        chk("idle_timeout1", 64'(timeout1), 64'd1);

        // Restart: two rises discarded, timeout held until the next publish.
        last = cyc;
        rise(50, 1'b0, 1'b0, 1'b0, 0, 0);
        rise(1000, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("timeout_held0", 64'(timeout0), 64'd1);
        for (int i = 0; i < 4; i++) rise(1000, 1'b0, 1'b1, i == 3, 1000, 1000);

        // Period equal to the timeout limit is a valid measurement.
        for (int i = 0; i < 4; i++) rise(c_TO, 1'b0, 1'b1, i == 3, c_TO, c_TO);

        // Reset pulsed mid-period clears the outputs without a clock edge.
        rise(1000, 1'b0, 1'b1, 1'b0, 1000, 0);
        while (cyc < last + 700) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_period0", 64'(period0), 64'd0);
        chk("async_valid0", 64'(valid0), 64'd0);
        chk("async_timeout0", 64'(timeout0), 64'd0);
        chk("async_period1", 64'(period1), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rise(1000, 1'b0, 1'b0, 1'b0, 0, 0);
        rise(1000, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) rise(1000, 1'b0, 1'b1, i == 3, 1000, 1000);

        repeat (10) @(negedge clk);
        chk("dut0_pending_results", 64'(q0.size()), 64'd0);
        chk("dut1_pending_results", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
